if_inst_resp_buffer: RTL and testbench
======================================

Name: if_inst_resp_buffer

Overview:
- Response-side companion of the IF stage, sitting between the instruction SRAM-like/icache interface and IF.
- Tracks accepted fetch requests and discards responses that belong to requests cancelled by a pipeline flush.
- Holds a returned instruction in a one-entry buffer when ID cannot accept it in the arrival cycle.
- Drives IF's data_ok, buffer_ok and buffer-rdata inputs, and a request-block signal back to pre-IF.

Parameters:
- DATA_WIDTH, 32: instruction width.
- MAX_OUTSTANDING, 2: maximum accepted requests awaiting data_ok.
- CNT_WIDTH, 2: width of the outstanding and cancel counters; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- inst_sram_req_i  in  1  fetch request valid toward the SRAM-like interface.
- inst_sram_addr_ok_i  in  1  request accepted; an accepted request is `req & addr_ok`.
- inst_sram_data_ok_i  in  1  raw response valid, returned in request order.
- inst_sram_rdata_i  in  DATA_WIDTH  raw response instruction.
- excep_flush_i  in  1  pipeline flush.
- if_valid_i  in  1  IF stage holds a valid instruction.
- id_allowin_i  in  1  ID accepts from IF this cycle.
- inst_sram_data_ok_o  out  1  filtered data_ok to IF.
- inst_sram_rdata_o  out  DATA_WIDTH  pass-through of inst_sram_rdata_i.
- inst_rdata_buffer_ok_o  out  1  buffer holds a valid instruction.
- inst_rdata_buffer_rdata_o  out  DATA_WIDTH  buffered instruction.
- req_block_o  out  1  pre-IF must not issue a new request.
- outstanding_cnt_o  out  CNT_WIDTH  accepted requests not yet answered.
- cancel_cnt_o  out  CNT_WIDTH  pending responses to discard.
- proto_err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n=0 at clk edge): all counters 0, buffer EMPTY, buffer rdata 0, proto_err_o 0.
  - While rst_n=0, all outputs are 0 except inst_sram_rdata_o, which still passes inst_sram_rdata_i.
  - Reset asserted mid-transaction drops all tracking; no cancel state survives reset.
- Definitions:
  - acc = inst_sram_req_i & inst_sram_addr_ok_i.
  - rsp = inst_sram_data_ok_i.
  - canc = rsp & (cancel_cnt_o != 0).
  - live = rsp & ~canc & ~excep_flush_i.
- Outstanding counter: next = cnt + acc - rsp.
  - acc and rsp in the same cycle leave it unchanged.
  - rsp with cnt=0 sets proto_err_o and leaves the counter at 0.
- Cancel counter:
  - On excep_flush_i: next = (outstanding_cnt + acc - rsp) minus the in-flight responses still in excess of that, i.e. every request accepted at or before the flush edge and not answered by the flush-cycle response is cancelled.
  - The flush-cycle response is itself discarded; it belongs to the flushed instruction.
  - Otherwise next = cancel_cnt - canc.
  - A flush while cancel_cnt>0 recomputes it from the outstanding count using the same formula; no double counting.
- Filtered data_ok: inst_sram_data_ok_o = live, combinational, 0-cycle latency.
- Buffer FSM, states EMPTY and FULL:
  - EMPTY→FULL when live & if_valid_i & ~id_allowin_i; capture inst_sram_rdata_i.
  - FULL→EMPTY when id_allowin_i (IF hands off to ID) or excep_flush_i. Flush has priority; the buffered data is discarded.
  - FULL & live: proto_err_o set, buffer contents kept, state unchanged.
  - inst_rdata_buffer_ok_o = (state==FULL). inst_rdata_buffer_rdata_o holds the captured value and is 0 after reset.
- req_block_o = (outstanding_cnt_o == MAX_OUTSTANDING) | (state==FULL). It is combinational from registered state.
- proto_err_o clears only on reset.

Test Plan:
- Single fetch: acc at cycle 0, rsp with rdata=0x02800C0C at cycle 2, id_allowin=1 → data_ok_o=1 at cycle 2; outstanding 1→0; buffer stays EMPTY.
- Stall capture: rsp rdata=0x1C000000 while if_valid=1 and id_allowin=0 → buffer_ok_o=1 from the next cycle with rdata 0x1C000000, req_block_o=1. Asserting id_allowin=1 for one cycle → buffer_ok_o=0 on the following cycle.
- Flush with two outstanding, no rsp in the flush cycle → cancel_cnt=2. The next two rsp give data_ok_o=0 and cancel_cnt 2→1→0. A third, fresh request's rsp gives data_ok_o=1.
- Flush while FULL with one outstanding → buffer EMPTY next cycle and cancel_cnt=1. The late rsp is dropped.
- Same-cycle acc+rsp at outstanding=1 → stays 1. Reaching outstanding=2 gives req_block_o=1.
- rsp with outstanding=0 → proto_err_o=1 sticky until rst_n=0. Reset mid-cancel → all counters 0 the next cycle.

Source files
------------

// File: rtl/if_inst_resp_buffer.sv
// IF-stage response buffer: filters responses of flushed fetches, holds one
// instruction while ID stalls, and throttles pre-IF via req_block_o.
module if_inst_resp_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_sram_req_i,
  input  logic                  inst_sram_addr_ok_i,
  input  logic                  inst_sram_data_ok_i,
  input  logic [DATA_WIDTH-1:0] inst_sram_rdata_i,
  input  logic                  excep_flush_i,
  input  logic                  if_valid_i,
  input  logic                  id_allowin_i,
  output logic                  inst_sram_data_ok_o,
  output logic [DATA_WIDTH-1:0] inst_sram_rdata_o,
  output logic                  inst_rdata_buffer_ok_o,
  output logic [DATA_WIDTH-1:0] inst_rdata_buffer_rdata_o,
  output logic                  req_block_o,
  output logic [CNT_WIDTH-1:0]  outstanding_cnt_o,
  output logic [CNT_WIDTH-1:0]  cancel_cnt_o,
  output logic                  proto_err_o
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]  cancel_q, cancel_d;
  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_rdata_q, buf_rdata_d;
  logic                  proto_err_q, proto_err_d;

  logic                  acc, rsp, canc, live, underflow;
  logic [CNT_WIDTH:0]    cnt_nxt;

  assign acc  = inst_sram_req_i & inst_sram_addr_ok_i;
  assign rsp  = inst_sram_data_ok_i;
  assign canc = rsp & (cancel_q != '0);
  assign live = rsp & ~canc & ~excep_flush_i;

  // A flush cancels every request still unanswered after this cycle, so the
  // cancel count is simply reloaded with the next outstanding count.
  always_comb begin
    cnt_nxt   = {1'b0, outstanding_q} + (CNT_WIDTH+1)'(acc);
    underflow = rsp & (outstanding_q == '0);
    if (rsp && (cnt_nxt != '0)) begin
      cnt_nxt = cnt_nxt - (CNT_WIDTH+1)'(1);
    end
    outstanding_d = cnt_nxt[CNT_WIDTH-1:0];
    if (excep_flush_i) begin
      cancel_d = outstanding_d;
    end else begin
      cancel_d = cancel_q - CNT_WIDTH'(canc);
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_rdata_d = buf_rdata_q;
    proto_err_d = proto_err_q | underflow;
    if (state_q == ST_FULL) begin
      if (live) begin
        proto_err_d = 1'b1;
      end
      if (excep_flush_i || id_allowin_i) begin
        state_d = ST_EMPTY;
      end
    end else if (live && if_valid_i && !id_allowin_i) begin
      state_d     = ST_FULL;
      buf_rdata_d = inst_sram_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      cancel_q      <= '0;
      state_q       <= ST_EMPTY;
      buf_rdata_q   <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      cancel_q      <= cancel_d;
      state_q       <= state_d;
      buf_rdata_q   <= buf_rdata_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Everything except the raw rdata pass-through reads as zero during reset.
  assign inst_sram_data_ok_o       = rst_n & live;
  assign inst_sram_rdata_o         = inst_sram_rdata_i;
  assign inst_rdata_buffer_ok_o    = rst_n & (state_q == ST_FULL);
  assign inst_rdata_buffer_rdata_o = rst_n ? buf_rdata_q : '0;
  assign req_block_o               = rst_n & ((outstanding_q == CNT_WIDTH'(MAX_OUTSTANDING)) |
                                              (state_q == ST_FULL));
  assign outstanding_cnt_o         = rst_n ? outstanding_q : '0;
  assign cancel_cnt_o              = rst_n ? cancel_q : '0;
  assign proto_err_o               = rst_n & proto_err_q;

endmodule

// File: tb/tb_if_inst_resp_buffer.sv
// Randomised and directed bench for if_inst_resp_buffer; a queue-based model
// tracks in-flight fetches and a monitor scores every filtered data_ok.
module tb_if_inst_resp_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, addr_ok = 1'b0, data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        flush = 1'b0, if_valid = 1'b0, allowin = 1'b0;

  logic        data_ok_o, buf_ok_o, req_block_o, proto_err_o;
  logic [31:0] rdata_o, buf_rdata_o;
  logic [1:0]  out_cnt_o, cancel_cnt_o;

  int checks = 0;
  int failures = 0;

  // Model: one bit per unanswered accepted request, set when it was cancelled.
  bit          m_q[$];
  bit          m_full = 1'b0;
  logic [31:0] m_data = '0;
  bit          m_err = 1'b0;
  logic [31:0] exp_q[$];
  logic        last_data_ok;

  always #5 clk = ~clk;

  if_inst_resp_buffer #(.DATA_WIDTH(32), .MAX_OUTSTANDING(2), .CNT_WIDTH(2)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .inst_sram_req_i          (req),
    .inst_sram_addr_ok_i      (addr_ok),
    .inst_sram_data_ok_i      (data_ok),
    .inst_sram_rdata_i        (rdata),
    .excep_flush_i            (flush),
    .if_valid_i               (if_valid),
    .id_allowin_i             (allowin),
    .inst_sram_data_ok_o      (data_ok_o),
    .inst_sram_rdata_o        (rdata_o),
    .inst_rdata_buffer_ok_o   (buf_ok_o),
    .inst_rdata_buffer_rdata_o(buf_rdata_o),
    .req_block_o              (req_block_o),
    .outstanding_cnt_o        (out_cnt_o),
    .cancel_cnt_o             (cancel_cnt_o),
    .proto_err_o              (proto_err_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_cancelled();
    int n = 0;
    foreach (m_q[i]) if (m_q[i]) n++;
    return n;
  endfunction

  function automatic bit m_live();
    bit head_c = (m_q.size() > 0) && m_q[0];
    return data_ok && !head_c && !flush;
  endfunction

  // One cycle: drive at negedge, queue the expected response, advance model at posedge.
  task automatic applyStimulus(input logic r, input logic a, input logic d, input logic [31:0] rd,
                               input logic f, input logic iv, input logic al);
    bit live, skip_acc;
    @(negedge clk);
    req = r; addr_ok = a; data_ok = d; rdata = rd; flush = f; if_valid = iv; allowin = al;
    live = m_live();
    if (rst_n && live) exp_q.push_back(rd);
    #3;
    last_data_ok = data_ok_o;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete(); m_full = 0; m_data = '0; m_err = 0;
    end else begin
      skip_acc = 0;
      if (d && m_q.size() == 0) m_err = 1;
      if (m_full && live) m_err = 1;
      if (m_full) begin
        if (f || al) m_full = 0;
      end else if (live && iv && !al) begin
        m_full = 1; m_data = rd;
      end
      if (d) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else skip_acc = 1;
      end
      if (r && a && !skip_acc) m_q.push_back(1'b0);
      if (f) foreach (m_q[i]) m_q[i] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  // Monitor: scoreboard for filtered data_ok plus registered-state comparison.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (!rst_n) begin
      checkOutput("reset_outputs_zero",
                  {24'h0, data_ok_o, buf_ok_o, req_block_o, proto_err_o, out_cnt_o, cancel_cnt_o} | buf_rdata_o,
                  32'h0);
      exp_q.delete();
    end else begin
      if (data_ok_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_data_ok", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("data_ok_rdata", rdata_o, e);
        end
      end else if (exp_q.size() > 0) begin
        checkOutput("missing_data_ok", 32'h0, 32'h1);
        exp_q.delete();
      end
      checkOutput("outstanding_cnt", 32'(out_cnt_o), 32'(m_q.size()));
      checkOutput("cancel_cnt", 32'(cancel_cnt_o), 32'(m_cancelled()));
      checkOutput("buffer_ok", 32'(buf_ok_o), 32'(m_full));
      checkOutput("buffer_rdata", buf_rdata_o, m_data);
      checkOutput("req_block", 32'(req_block_o), 32'((m_q.size() == 2) || m_full));
      checkOutput("proto_err", 32'(proto_err_o), 32'(m_err));
    end
  end

  initial begin
    bit can_req, can_rsp;
    rst_n = 0;
    idle(2);
    rst_n = 1;
    idle(1);
    checkOutput("reset_out_cnt", 32'(out_cnt_o), 32'd0);

    // single fetch
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    #1 checkOutput("single_cnt_after_acc", 32'(out_cnt_o), 32'd1);
    idle(1);
    applyStimulus(0, 0, 1, 32'h02800C0C, 0, 1, 1);
    checkOutput("single_data_ok", 32'(last_data_ok), 32'd1);
    #1 checkOutput("single_cnt_after_rsp", 32'(out_cnt_o), 32'd0);
    checkOutput("single_buf_empty", 32'(buf_ok_o), 32'd0);

    // stall capture
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h1C000000, 0, 1, 0);
    #1 checkOutput("stall_buf_ok", 32'(buf_ok_o), 32'd1);
    checkOutput("stall_buf_rdata", buf_rdata_o, 32'h1C000000);
    checkOutput("stall_req_block", 32'(req_block_o), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 1);
    #1 checkOutput("stall_release", 32'(buf_ok_o), 32'd0);

    // flush with two outstanding
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    #1 checkOutput("two_out_req_block", 32'(req_block_o), 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 1, 0, 0);
    #1 checkOutput("flush_cancel_2", 32'(cancel_cnt_o), 32'd2);
    applyStimulus(0, 0, 1, 32'hDEAD0001, 0, 1, 1);
    checkOutput("cancel_drop_1", 32'(last_data_ok), 32'd0);
    #1 checkOutput("cancel_cnt_1", 32'(cancel_cnt_o), 32'd1);
    applyStimulus(0, 0, 1, 32'hDEAD0002, 0, 1, 1);
    checkOutput("cancel_drop_2", 32'(last_data_ok), 32'd0);
    #1 checkOutput("cancel_cnt_0", 32'(cancel_cnt_o), 32'd0);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h00000013, 0, 1, 1);
    checkOutput("fresh_after_cancel", 32'(last_data_ok), 32'd1);

    // flush while FULL with one outstanding
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'hAAAA5555, 0, 1, 0);
    applyStimulus(0, 0, 0, 32'h0, 1, 1, 0);
    #1 checkOutput("flush_full_empty", 32'(buf_ok_o), 32'd0);
    checkOutput("flush_full_cancel", 32'(cancel_cnt_o), 32'd1);
    applyStimulus(0, 0, 1, 32'h5555AAAA, 0, 1, 1);
    checkOutput("flush_full_late_drop", 32'(last_data_ok), 32'd0);

    // same-cycle acc+rsp
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(1, 1, 1, 32'h12345678, 0, 1, 1);
    #1 checkOutput("acc_rsp_same_cycle", 32'(out_cnt_o), 32'd1);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    #1 checkOutput("max_out_block", 32'(req_block_o), 32'd1);
    applyStimulus(0, 0, 1, 32'h11111111, 0, 1, 1);
    applyStimulus(0, 0, 1, 32'h22222222, 0, 1, 1);
    checkOutput("no_early_err", 32'(proto_err_o), 32'd0);

    // protocol error and reset mid-cancel
    applyStimulus(0, 0, 1, 32'h33333333, 0, 1, 1);
    #1 checkOutput("proto_err_set", 32'(proto_err_o), 32'd1);
    idle(3);
    checkOutput("proto_err_sticky", 32'(proto_err_o), 32'd1);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 1, 0, 0);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(1);
    checkOutput("post_reset_cancel", 32'(cancel_cnt_o), 32'd0);
    checkOutput("post_reset_out", 32'(out_cnt_o), 32'd0);
    checkOutput("post_reset_err", 32'(proto_err_o), 32'd0);

    // random traffic from a well-behaved pre-IF and in-order SRAM
    for (int i = 0; i < 3000; i++) begin
      can_req = !((m_q.size() == 2) || m_full);
      can_rsp = (m_q.size() > 0) && (!m_full || m_q[0]);
      applyStimulus(can_req && ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 2) != 0,
                    can_rsp && ($urandom_range(0, 2) != 0),
                    $urandom,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1);
    end
    idle(2);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
